tdc_run_controller: RTL and testbench
=====================================

Name: tdc_run_controller

Overview:
Run/stop/lap/clear sequencer for the two-digit seconds counter datapath.
- Conditions three raw push-buttons: synchronise, debounce, rising-edge detect.
- Runs a stopwatch state machine.
- Generates the one-cycle count-enable tick (replaces the free-running divider), a counter-clear pulse and a display-freeze control for the 7-segment path.
- Sits between the board buttons/system clock and the counter + BCD-to-7-segment blocks.

Parameters:
DIV, 50000000, system clocks per count tick (>=2)
DIV_W, 26, prescaler width, 2^DIV_W >= DIV
DB_CYCLES, 1000000, consecutive stable samples required to accept a button level change (>=2)
DB_W, 20, debounce counter width, 2^DB_W >= DB_CYCLES

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
btn_startstop  in  1  raw start/stop button, active-high, asynchronous to clock
btn_lap  in  1  raw lap button, active-high, asynchronous
btn_clear  in  1  raw clear button, active-high, asynchronous
count_en  out  1  one-cycle tick to the counter's increment enable
count_clr  out  1  one-cycle synchronous clear to the counter
latch_display  out  1  level; 1 = display path holds its last value
state  out  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11
running  out  1  1 in RUN or LAP

Behaviour:
Interface: one clock, `clock`. `reset` is synchronous and active-low: sampled only on the rising edge of `clock`, and reset==0 forces the reset state.

Reset:
- state=IDLE; prescaler=0; all sync flops, debounced levels, edge-history flops and debounce counters = 0.
- Outputs: count_en=0, count_clr=0, latch_display=0, running=0.

Button conditioning (identical per button):
- 2-flop synchroniser (s1 -> s2).
- Debounce:
  - If s2 != db_level, the counter increments; otherwise it resets to 0.
  - When the counter reaches DB_CYCLES-1 and s2 still differs, db_level <= s2 and the counter resets to 0.
- press = db_level & ~db_prev: exactly one cycle per accepted rising edge. Release is never an event.
- Fixed latency: press is high DB_CYCLES+2 clocks after raw input first sampled high.
- Pulses shorter than DB_CYCLES clocks at s2 produce no event.
- A button held through reset yields one press after reset deasserts.

Event priority, same cycle: clear > startstop > lap. Only the highest-priority event that is legal in the current state acts. Illegal events are dropped, not queued.

State machine (registered; transitions on the edge after the press cycle):
- IDLE: startstop -> RUN; clear -> IDLE with count_clr; lap ignored.
- RUN: startstop -> PAUSE; lap -> LAP; clear ignored.
- LAP: lap -> RUN; startstop -> PAUSE; clear ignored.
- PAUSE: startstop -> RUN; clear -> IDLE with count_clr; lap ignored.

Outputs:
- latch_display: registered, 1 iff state==LAP.
- running: 1 iff state is RUN or LAP.
- count_clr: registered, high for exactly the first cycle in IDLE after the clear transition (also for the IDLE self-clear case).

Prescaler:
- Counts 0..DIV-1 while running; wraps DIV-1 -> 0.
- Holds its value in PAUSE, so resume preserves the partial second.
- Forced to 0 in IDLE.
- count_en = running & (prescaler == DIV-1), decoded from registers.
- A tick coinciding with the cycle a stop press is registered is still issued, because state is still RUN.
- First tick after IDLE->RUN: DIV cycles after state becomes RUN.
- count_en and count_clr are never high in the same cycle.

Reset mid-operation: any state returns to IDLE next edge. In-flight debounce counts are discarded; no pulse is emitted.

Test Plan:
(All scenarios use DIV=4, DB_CYCLES=3.)
1. Reset: reset=0 for 5 cycles with all buttons 0 -> state=00, count_en=0, count_clr=0, latch_display=0, running=0 throughout and after release.
2. Start: btn_startstop high 6 cycles -> press 5 clocks after first sample; state=01 next edge; count_en high every 4th cycle, first at cycle 4 in RUN.
3. Lap: lap press in RUN -> state=11, latch_display=1, count_en cadence unbroken; second lap -> state=01, latch_display=0.
4. Pause/resume: stop press with prescaler=1 -> state=10, no count_en for 20 cycles; start press -> first count_en 2 cycles after state=01.
5. Clear: clear in RUN -> ignored, state stays 01. Clear in PAUSE -> state=00, count_clr high exactly 1 cycle, prescaler=0. Clear+startstop debounced same cycle in PAUSE -> IDLE (clear wins).
6. Glitch/reset: 2-cycle raw pulse on btn_startstop -> no event. Reset=0 for one cycle while in LAP -> state=00, latch_display=0 next cycle.

Source files
------------

// File: rtl/tdc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_run_controller
//  Purpose  : Stopwatch run/stop/lap/clear sequencer. Conditions three raw
//             push-buttons (sync, debounce, rising-edge detect), runs the
//             IDLE/RUN/PAUSE/LAP state machine and generates the counter
//             tick, counter clear and display-freeze controls.
//  Revision : 1.0 - initial release
// ============================================================================
module tdc_run_controller #(
  parameter int DIV       = 50000000,
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       latch_display,
  output logic [1:0] state,
  output logic       running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  localparam logic [DB_W-1:0]  C_DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);

  // Button index: 0 = start/stop, 1 = lap, 2 = clear
  logic [2:0] w_raw;
  logic [2:0] w_press;

  assign w_raw = {btn_clear, btn_lap, btn_startstop};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            r_s1;
    logic            r_s2;
    logic            r_lvl;
    logic            r_prev;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // Synchronise, debounce and register a one-cycle pulse on each accepted rising level
    always_ff @(posedge clock) begin
      if (!reset) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_lvl   <= 1'b0;
        r_prev  <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_raw[gi];
        r_s2    <= r_s1;
        r_prev  <= r_lvl;
        r_press <= r_lvl & ~r_prev;
        if (r_s2 != r_lvl) begin
          if (r_cnt == C_DB_LAST) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_clr_go;
  logic             r_clr;
  logic             r_latch;
  logic             w_running;
  logic [DIV_W-1:0] r_presc;

  assign w_running = (r_state == S_RUN) || (r_state == S_LAP);

  // Next-state decode: within a state only the highest-priority legal event acts
  always_comb begin
    w_next   = r_state;
    w_clr_go = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press[2]) begin
          w_next   = S_IDLE;
          w_clr_go = 1'b1;
        end else if (w_press[0]) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_press[0])      w_next = S_PAUSE;
        else if (w_press[1]) w_next = S_LAP;
      end
      S_LAP: begin
        if (w_press[0])      w_next = S_PAUSE;
        else if (w_press[1]) w_next = S_RUN;
      end
      S_PAUSE: begin
        if (w_press[2]) begin
          w_next   = S_IDLE;
          w_clr_go = 1'b1;
        end else if (w_press[0]) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered clear pulse and display-freeze level
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_clr   <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clr   <= w_clr_go;
      r_latch <= (w_next == S_LAP);
    end
  end

  // Prescaler: wraps while running, holds in PAUSE so a resume keeps the partial second
  always_ff @(posedge clock) begin
    if (!reset || (r_state == S_IDLE)) begin
      r_presc <= '0;
    end else if (w_running) begin
      if (r_presc == C_DIV_LAST) r_presc <= '0;
      else                       r_presc <= r_presc + 1'b1;
    end
  end

  assign count_en      = w_running && (r_presc == C_DIV_LAST);
  assign count_clr     = r_clr;
  assign latch_display = r_latch;
  assign state         = r_state;
  assign running       = w_running;

endmodule
`default_nettype wire

// File: tb/tb_tdc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdc_run_controller
//  Purpose  : Directed self-checking bench for tdc_run_controller with
//             DIV=4, DB_CYCLES=3. Expected output vectors are queued when a
//             step is driven and popped when the DUT result is sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_run_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_startstop;
  logic       btn_lap;
  logic       btn_clear;
  logic       count_en;
  logic       count_clr;
  logic       latch_display;
  logic [1:0] state;
  logic       running;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;
  localparam logic [1:0] C_LAP   = 2'b11;

  localparam logic [2:0] C_SS  = 3'b001;
  localparam logic [2:0] C_LP  = 3'b010;
  localparam logic [2:0] C_CL  = 3'b100;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];

  tdc_run_controller #(
    .DIV       (4),
    .DIV_W     (3),
    .DB_CYCLES (3),
    .DB_W      (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_startstop (btn_startstop),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clear),
    .count_en      (count_en),
    .count_clr     (count_clr),
    .latch_display (latch_display),
    .state         (state),
    .running       (running)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then step just past the edge so outputs are settled
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Queue an expected vector {state, count_en, count_clr, latch_display, running}
  task automatic push(input string tag, input logic [1:0] st, input logic en,
                      input logic clr, input logic lat);
    exp_t e;
    e.tag = tag;
    e.v   = {st, en, clr, lat, ((st == C_RUN) || (st == C_LAP))};
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now
  task automatic check_pop();
    exp_t       e;
    logic [5:0] obs;
    obs = {state, count_en, count_clr, latch_display, running};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%b expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st, input logic en,
                            input logic clr, input logic lat);
    push(tag, st, en, clr, lat);
    check_pop();
  endtask

  // Hold buttons m={clear,lap,startstop} for 6 cycles, release, and check the
  // first cycle after the resulting transition edge
  task automatic press(input logic [2:0] m, input string tag, input logic [1:0] st,
                       input logic en, input logic clr, input logic lat);
    push(tag, st, en, clr, lat);
    {btn_clear, btn_lap, btn_startstop} = m;
    cyc(6);
    {btn_clear, btn_lap, btn_startstop} = 3'b000;
    cyc(1);
    check_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    btn_startstop = 1'b0;
    btn_lap       = 1'b0;
    btn_clear     = 1'b0;

    // Reset held for 5 cycles, then released
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      expect_now("reset_hold", C_IDLE, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    cyc(1);
    expect_now("reset_release", C_IDLE, 1'b0, 1'b0, 1'b0);

    // Start: first RUN cycle R1, tick on R4 and R8
    press(C_SS, "start_run", C_RUN, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      cyc(1);
      expect_now("run_cadence", C_RUN, (i % 4 == 0), 1'b0, 1'b0);
    end

    // Lap in RUN: LAP at R15, cadence continues (tick R16, R20)
    press(C_LP, "lap_enter", C_LAP, 1'b0, 1'b0, 1'b1);
    for (int i = 16; i <= 20; i++) begin
      cyc(1);
      expect_now("lap_cadence", C_LAP, (i % 4 == 0), 1'b0, 1'b1);
    end
    // Second lap: back to RUN at R27
    press(C_LP, "lap_exit", C_RUN, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_now("run_after_lap_tick", C_RUN, 1'b1, 1'b0, 1'b0);

    // Stop with prescaler=1 in the press cycle (R34): PAUSE from R35
    press(C_SS, "pause_enter", C_PAUSE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      expect_now("pause_hold", C_PAUSE, 1'b0, 1'b0, 1'b0);
    end

    // Resume: partial second preserved, tick on the second RUN cycle
    press(C_SS, "resume_run", C_RUN, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_now("resume_first_tick", C_RUN, 1'b1, 1'b0, 1'b0);
    cyc(1);
    expect_now("resume_after_tick", C_RUN, 1'b0, 1'b0, 1'b0);

    // Clear in RUN is ignored
    press(C_CL, "clear_in_run_ignored", C_RUN, 1'b1, 1'b0, 1'b0);

    // Stop, then clear from PAUSE
    press(C_SS, "pause_again", C_PAUSE, 1'b0, 1'b0, 1'b0);
    press(C_CL, "clear_from_pause", C_IDLE, 1'b0, 1'b1, 1'b0);
    cyc(1);
    expect_now("clear_pulse_one_cycle", C_IDLE, 1'b0, 1'b0, 1'b0);

    // Restart: prescaler was zeroed, tick on fourth RUN cycle
    press(C_SS, "restart_run", C_RUN, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      cyc(1);
      expect_now("restart_cadence", C_RUN, (i == 4), 1'b0, 1'b0);
    end
    cyc(2);
    press(C_SS, "pause_for_combo", C_PAUSE, 1'b0, 1'b0, 1'b0);

    // Clear and start/stop together in PAUSE: clear wins, start not queued
    cyc(5);
    press(C_CL | C_SS, "combo_clear_wins", C_IDLE, 1'b0, 1'b1, 1'b0);
    cyc(1);
    expect_now("combo_no_queue", C_IDLE, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_now("combo_still_idle", C_IDLE, 1'b0, 1'b0, 1'b0);

    // IDLE self-clear and lap ignored in IDLE
    cyc(5);
    press(C_CL, "idle_self_clear", C_IDLE, 1'b0, 1'b1, 1'b0);
    cyc(5);
    press(C_LP, "lap_in_idle_ignored", C_IDLE, 1'b0, 1'b0, 1'b0);

    // Two-cycle raw glitch produces no event
    cyc(5);
    btn_startstop = 1'b1;
    cyc(2);
    btn_startstop = 1'b0;
    cyc(8);
    expect_now("glitch_rejected", C_IDLE, 1'b0, 1'b0, 1'b0);

    // Enter LAP, then a single-cycle reset returns to IDLE
    press(C_SS, "run_before_reset", C_RUN, 1'b0, 1'b0, 1'b0);
    cyc(5);
    press(C_LP, "lap_before_reset", C_LAP, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(1);
    expect_now("reset_in_lap", C_IDLE, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(3);
    expect_now("after_reset_idle", C_IDLE, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
